// File: rtl/glyph_memory.sv
// glyph_memory: multi-glyph bitmap store for the text path.
// Holds NUM_GLYPHS glyphs of GLYPH_W x GLYPH_H pixels, one row word per address
// (addr = glyph*GLYPH_H + row). A sequencer loads DEFAULT_GLYPH into every glyph
// after reset or on i_init_start. There is a masked row-write port and a
// 1-cycle registered read port that returns the row word and one addressed pixel.
module glyph_memory #(
  parameter int GLYPH_W    = 4,
  parameter int GLYPH_H    = 5,
  parameter int NUM_GLYPHS = 16,
  parameter logic [GLYPH_W*GLYPH_H-1:0] DEFAULT_GLYPH = 20'hA5AA5,
  localparam int GI_W  = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1,
  localparam int RI_W  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
  localparam int CI_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1
) (
  input  logic               i_clock,
  input  logic               i_rst,
  input  logic               i_init_start,
  output logic               o_busy,
  input  logic               i_wr_en,
  input  logic [GI_W-1:0]    i_wr_glyph,
  input  logic [RI_W-1:0]    i_wr_row,
  input  logic [GLYPH_W-1:0] i_wr_data,
  input  logic [GLYPH_W-1:0] i_wr_mask,
  input  logic               i_rd_en,
  input  logic [GI_W-1:0]    i_rd_glyph,
  input  logic [RI_W-1:0]    i_rd_row,
  input  logic [CI_W-1:0]    i_rd_col,
  output logic               o_rd_valid,
  output logic [GLYPH_W-1:0] o_rd_data,
  output logic               o_rd_pixel
);
  localparam int DEPTH = NUM_GLYPHS * GLYPH_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_ptr;
  logic [RI_W-1:0]   r_irow;   // ptr % GLYPH_H, tracked alongside ptr to avoid a divider
  logic              r_busy;
  logic [GLYPH_W-1:0] r_mem [DEPTH];
  logic              r_rd_valid;
  logic [GLYPH_W-1:0] r_rd_data;
  logic              r_rd_pixel;

  logic               w_wr_ok;
  logic [AW-1:0]      w_wr_addr;
  logic               w_rd_ok;
  logic               w_rd_inrange;
  logic [AW-1:0]      w_rd_addr;
  logic [GLYPH_W-1:0] w_def_row;
  logic [GLYPH_W-1:0] w_rd_word;
  logic               w_rd_pix;

  // Address decode, range checks, default-row select and read mux
  always_comb begin
    w_wr_ok      = i_wr_en && (r_state == S_IDLE) &&
                   (int'(i_wr_glyph) < NUM_GLYPHS) && (int'(i_wr_row) < GLYPH_H);
    w_wr_addr    = AW'(int'(i_wr_glyph) * GLYPH_H + int'(i_wr_row));
    w_rd_ok      = i_rd_en && (r_state == S_IDLE);
    w_rd_inrange = (int'(i_rd_glyph) < NUM_GLYPHS) && (int'(i_rd_row) < GLYPH_H);
    w_rd_addr    = AW'(int'(i_rd_glyph) * GLYPH_H + int'(i_rd_row));
    w_def_row    = DEFAULT_GLYPH[int'(r_irow)*GLYPH_W +: GLYPH_W];
    w_rd_word    = w_rd_inrange ? r_mem[w_rd_addr] : '0;
    w_rd_pix     = (int'(i_rd_col) < GLYPH_W) ? w_rd_word[i_rd_col] : 1'b0;
  end

  // Init sequencer FSM: INIT walks every address once, then IDLE until reload
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_irow  <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_ptr == AW'(DEPTH-1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_irow  <= '0;
          end else begin
            r_ptr  <= r_ptr + 1'b1;
            r_irow <= (r_irow == RI_W'(GLYPH_H-1)) ? '0 : r_irow + 1'b1;
          end
        end
        S_IDLE: begin
          if (i_init_start) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_irow  <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Storage: sequencer load during INIT, masked user write during IDLE
  always_ff @(posedge i_clock) begin
    if (!i_rst) begin
      if (r_state == S_INIT)
        r_mem[r_ptr] <= w_def_row;
      else if (w_wr_ok)
        r_mem[w_wr_addr] <= (r_mem[w_wr_addr] & ~i_wr_mask) | (i_wr_data & i_wr_mask);
    end
  end

  // Registered read port; data holds when no read is accepted
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_pixel <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data  <= w_rd_word;
        r_rd_pixel <= w_rd_pix;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_pixel = r_rd_pixel;
endmodule

// File: tb/tb_glyph_memory.sv
// Directed bench for glyph_memory: default config plus a 6x7x3 config.
module tb_glyph_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration (4x5, 16 glyphs)
  logic       rst, init_start, busy, wr_en, rd_en, rd_valid, rd_pixel;
  logic [3:0] wr_glyph, rd_glyph, wr_data, wr_mask, rd_data;
  logic [2:0] wr_row, rd_row;
  logic [1:0] rd_col;

  glyph_memory u_dut (
    .i_clock(clk), .i_rst(rst), .i_init_start(init_start), .o_busy(busy),
    .i_wr_en(wr_en), .i_wr_glyph(wr_glyph), .i_wr_row(wr_row),
    .i_wr_data(wr_data), .i_wr_mask(wr_mask),
    .i_rd_en(rd_en), .i_rd_glyph(rd_glyph), .i_rd_row(rd_row), .i_rd_col(rd_col),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_pixel(rd_pixel)
  );

  // second configuration (6 wide, 7 rows, 3 glyphs)
  logic       rst2, busy2, rd_en2, rd_valid2, rd_pixel2;
  logic [1:0] rd_glyph2;
  logic [2:0] rd_row2, rd_col2;
  logic [5:0] rd_data2;
  logic       wr_en2 = 1'b0, init_start2 = 1'b0;
  logic [1:0] wr_glyph2 = '0;
  logic [2:0] wr_row2 = '0;
  logic [5:0] wr_data2 = '0, wr_mask2 = '0;

  glyph_memory #(.GLYPH_W(6), .GLYPH_H(7), .NUM_GLYPHS(3),
                 .DEFAULT_GLYPH(42'h3123456789A)) u_dut2 (
    .i_clock(clk), .i_rst(rst2), .i_init_start(init_start2), .o_busy(busy2),
    .i_wr_en(wr_en2), .i_wr_glyph(wr_glyph2), .i_wr_row(wr_row2),
    .i_wr_data(wr_data2), .i_wr_mask(wr_mask2),
    .i_rd_en(rd_en2), .i_rd_glyph(rd_glyph2), .i_rd_row(rd_row2), .i_rd_col(rd_col2),
    .o_rd_valid(rd_valid2), .o_rd_data(rd_data2), .o_rd_pixel(rd_pixel2)
  );

  int tests = 0, fails = 0;

  typedef struct { int g; int r; int c; logic [3:0] d; logic p; } vec_t;
  vec_t vt[10];
  logic [3:0] def_rows[5];
  logic [5:0] def2_rows[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic rd1(input int g, input int r, input int c,
                     output logic v, output logic [3:0] d, output logic p);
    rd_en = 1'b1; rd_glyph = 4'(g); rd_row = 3'(r); rd_col = 2'(c);
    @(negedge clk);
    rd_en = 1'b0;
    v = rd_valid; d = rd_data; p = rd_pixel;
  endtask

  task automatic wr1(input int g, input int r, input logic [3:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_glyph = 4'(g); wr_row = 3'(r); wr_data = d; wr_mask = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Count negedges with busy high; also counts rd_valid pulses seen meanwhile.
  task automatic busy_count(output int b, output int vc);
    b = 0; vc = 0;
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      b++;
      if (rd_valid) vc++;
      @(negedge clk);
    end
    if (rd_valid) vc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic v, p;
    logic [3:0] d;
    int b, vc, errs;

    def_rows = '{4'h5, 4'hA, 4'hA, 4'h5, 4'hA};
    def2_rows = '{6'h1A, 6'h22, 6'h27, 6'h15, 6'h34, 6'h08, 6'h31};
    vt[0] = '{0, 0, 1, 4'h5, 1'b0};
    vt[1] = '{0, 1, 0, 4'hA, 1'b0};
    vt[2] = '{0, 2, 1, 4'hA, 1'b1};
    vt[3] = '{0, 3, 2, 4'h5, 1'b1};
    vt[4] = '{0, 4, 3, 4'hA, 1'b1};
    vt[5] = '{15, 4, 0, 4'hA, 1'b0};
    vt[6] = '{15, 0, 0, 4'h5, 1'b1};
    vt[7] = '{8, 3, 3, 4'h5, 1'b0};
    vt[8] = '{0, 6, 0, 4'h0, 1'b0};
    vt[9] = '{4, 7, 1, 4'h0, 1'b0};

    rst = 1'b1; rst2 = 1'b1; init_start = 1'b0;
    wr_en = 1'b0; wr_glyph = '0; wr_row = '0; wr_data = '0; wr_mask = '0;
    rd_en = 1'b0; rd_glyph = '0; rd_row = '0; rd_col = '0;
    rd_en2 = 1'b0; rd_glyph2 = '0; rd_row2 = '0; rd_col2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_pixel", 32'(rd_pixel), 0);

    rst = 1'b0;
    busy_count(b, vc);
    chk("init_busy_cycles", 32'(b), 80);

    // table of reads against the default pattern
    for (int i = 0; i < 10; i++) begin
      rd1(vt[i].g, vt[i].r, vt[i].c, v, d, p);
      chk($sformatf("vec%0d_valid", i), 32'(v), 1);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vt[i].d));
      chk($sformatf("vec%0d_pixel", i), 32'(p), 32'(vt[i].p));
    end

    // back-to-back reads, then hold when idle
    rd_en = 1'b1; rd_glyph = 4'd1; rd_row = 3'd0; rd_col = 2'd0;
    @(negedge clk);
    rd_row = 3'd1;
    chk("b2b_first", 32'(rd_data), 32'h5);
    @(negedge clk);
    rd_en = 1'b0;
    chk("b2b_second_valid", 32'(rd_valid), 1);
    chk("b2b_second", 32'(rd_data), 32'hA);
    @(negedge clk);
    chk("hold_valid_low", 32'(rd_valid), 0);
    chk("hold_data", 32'(rd_data), 32'hA);

    // full write, then masked write
    wr1(3, 2, 4'hC, 4'hF);
    rd1(3, 2, 0, v, d, p);
    chk("wr_full_valid", 32'(v), 1);
    chk("wr_full", 32'(d), 32'hC);
    wr1(3, 2, 4'h3, 4'h1);
    rd1(3, 2, 0, v, d, p);
    chk("wr_masked", 32'(d), 32'hD);

    // same-cycle write+read: read sees old data
    wr_en = 1'b1; wr_glyph = 4'd7; wr_row = 3'd0; wr_data = 4'hF; wr_mask = 4'hF;
    rd_en = 1'b1; rd_glyph = 4'd7; rd_row = 3'd0; rd_col = 2'd0;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rbw_old", 32'(rd_data), 32'h5);
    rd1(7, 0, 0, v, d, p);
    chk("rbw_new", 32'(d), 32'hF);

    // out-of-range write row 5 of glyph 2 would alias glyph 3 row 0
    wr1(2, 5, 4'h0, 4'hF);
    rd1(3, 0, 0, v, d, p);
    chk("oor_wr_alias", 32'(d), 32'h5);
    errs = 0;
    for (int r = 0; r < 5; r++) begin
      rd1(2, r, 0, v, d, p);
      if (d !== def_rows[r]) errs++;
    end
    chk("oor_wr_rows_intact", 32'(errs), 0);

    // reload during which reads/writes/init_start are ignored
    wr1(5, 1, 4'h0, 4'hF);
    rd1(5, 1, 0, v, d, p);
    chk("pre_init_wr", 32'(d), 32'h0);
    init_start = 1'b1;
    @(negedge clk);
    rd_en = 1'b1; rd_glyph = 4'd5; rd_row = 3'd1;
    wr_en = 1'b1; wr_glyph = 4'd5; wr_row = 3'd1; wr_data = 4'h0; wr_mask = 4'hF;
    busy_count(b, vc);
    init_start = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    chk("reload_busy_cycles", 32'(b), 80);
    chk("reload_no_valid", 32'(vc), 0);
    rd1(5, 1, 0, v, d, p);
    chk("reload_restored", 32'(d), 32'hA);

    // reset in the middle of a reload
    wr1(9, 2, 4'h0, 4'hF);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_count(b, vc);
    chk("midrst_busy_cycles", 32'(b), 80);
    errs = 0;
    for (int g = 0; g < 16; g++)
      for (int r = 0; r < 5; r++) begin
        rd1(g, r, 0, v, d, p);
        if (v !== 1'b1 || d !== def_rows[r]) errs++;
      end
    chk("midrst_all_default", 32'(errs), 0);

    // rst drops a read issued in the same cycle
    rd_en = 1'b1; rd_glyph = 4'd0; rd_row = 3'd1; rst = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; rst = 1'b0;
    chk("rst_drops_read", 32'(rd_valid), 0);
    chk("rst_clears_data", 32'(rd_data), 0);

    // second configuration: 21-entry init and readback
    rst2 = 1'b0;
    b = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy2) break;
      b++;
      @(negedge clk);
    end
    chk("cfg2_busy_cycles", 32'(b), 21);
    errs = 0;
    for (int g = 0; g < 3; g++)
      for (int r = 0; r < 7; r++) begin
        rd_en2 = 1'b1; rd_glyph2 = 2'(g); rd_row2 = 3'(r); rd_col2 = 3'd0;
        @(negedge clk);
        rd_en2 = 1'b0;
        if (rd_valid2 !== 1'b1 || rd_data2 !== def2_rows[r]) errs++;
      end
    chk("cfg2_readback", 32'(errs), 0);
    rd_en2 = 1'b1; rd_glyph2 = 2'd3; rd_row2 = 3'd0; rd_col2 = 3'd0;
    @(negedge clk);
    chk("cfg2_oor_glyph_valid", 32'(rd_valid2), 1);
    chk("cfg2_oor_glyph_data", 32'(rd_data2), 0);
    rd_glyph2 = 2'd1; rd_row2 = 3'd2; rd_col2 = 3'd5;
    @(negedge clk);
    chk("cfg2_col5_pixel", 32'(rd_pixel2), 1);
    rd_col2 = 3'd6;
    @(negedge clk);
    rd_en2 = 1'b0;
    chk("cfg2_col6_pixel", 32'(rd_pixel2), 0);
    chk("cfg2_col6_data", 32'(rd_data2), 32'h27);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/glyph_memory.md
Name: glyph_memory

Overview:
Parametrised multi-glyph bitmap store for the character/text path of the VGA GPU. It holds NUM_GLYPHS glyphs of GLYPH_W x GLYPH_H pixels, one row word per address. A built-in sequencer loads every glyph with a default pattern after reset or on command. There is a masked row-write port and a registered read port that returns both the whole row and a single addressed pixel.

Parameters:
GLYPH_W, 4, pixels per glyph row (row word width), >=2
GLYPH_H, 5, rows per glyph, >=2
NUM_GLYPHS, 16, glyphs stored, >=1
DEFAULT_GLYPH, 20'hA5AA5, GLYPH_W*GLYPH_H init pattern; row r = DEFAULT_GLYPH[r*GLYPH_W +: GLYPH_W]
(derived) GI_W = max(1,$clog2(NUM_GLYPHS)), RI_W = max(1,$clog2(GLYPH_H)), CI_W = max(1,$clog2(GLYPH_W)), DEPTH = NUM_GLYPHS*GLYPH_H

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
init_start  in  1  request reload of all glyphs with DEFAULT_GLYPH
busy  out  1  init sequence in progress; read and write ports ignored
wr_en  in  1  row write strobe
wr_glyph  in  GI_W  glyph index for write
wr_row  in  RI_W  row index for write
wr_data  in  GLYPH_W  row data
wr_mask  in  GLYPH_W  per-pixel write enable (1 = update bit)
rd_en  in  1  read strobe
rd_glyph  in  GI_W  glyph index for read
rd_row  in  RI_W  row index for read
rd_col  in  CI_W  pixel column for rd_pixel
rd_valid  out  1  one-cycle pulse; read result valid
rd_data  out  GLYPH_W  row word read
rd_pixel  out  1  rd_data bit rd_col

Behaviour:
- Address of (g,r) = g*GLYPH_H + r. Storage is DEPTH x GLYPH_W registers. Contents are not cleared directly by rst; the sequencer loads them.
- States: INIT, IDLE.
- While rst=1: state=INIT, ptr=0, busy=1, rd_valid=0, rd_data=0, rd_pixel=0.
- INIT, rst=0: each cycle writes row ptr%GLYPH_H of DEFAULT_GLYPH into address ptr, then ptr++.
  - The cycle that writes ptr=DEPTH-1 moves to IDLE.
  - busy is high for exactly DEPTH cycles after rst falls, and low from the next cycle.
- IDLE with init_start=1: INIT next cycle, ptr=0, busy=1. Any wr_en/rd_en in that same cycle is still serviced.
- init_start in INIT is ignored; no restart.
- rst during INIT or IDLE restarts the sequence from ptr=0 and drops any pending read.
- Write, IDLE only:
  - mem[a] <= (mem[a] & ~wr_mask) | (wr_data & wr_mask).
  - Ignored if wr_glyph>=NUM_GLYPHS or wr_row>=GLYPH_H.
  - Zero-cycle effect visible to reads issued the following cycle.
- Read, IDLE only: the cycle after rd_en=1, rd_valid=1 and rd_data=mem[a], rd_pixel=rd_data[rd_col].
  - Latency is exactly 1. Back-to-back reads every cycle are supported.
  - Out-of-range glyph/row: rd_valid=1, rd_data=0.
  - rd_col>=GLYPH_W: rd_pixel=0.
- rd_en during busy: no rd_valid, ever. The request is dropped, not queued.
- rd_data/rd_pixel hold their last value when rd_valid=0.
- Simultaneous wr_en and rd_en to the same address: the read returns pre-write data (read-before-write). The new data appears on the next read.
- Bit 0 of a row word is pixel column 0, the leftmost on screen.

Test Plan:
- Default params; rst high 2 cycles then low -> busy high exactly 80 cycles then 0. Reading glyph 0 rows 0..4 returns 0101,1010,1010,0101,1010; glyph 15 row 4 = 1010; rd_col=1 on row 0 gives rd_pixel=0.
- Glyph 3 row 2, wr_data=1100, wr_mask=1111, then read -> rd_data=1100 one cycle after rd_en. Then wr_data=0011, wr_mask=0001 -> read gives 1101.
- Same-cycle wr_en+rd_en to glyph 7 row 0 with data 1111 -> that read returns 0101; next read returns 1111.
- Write glyph 5 row 1 =0000, pulse init_start, issue rd_en and wr_en during busy -> no rd_valid for 80 cycles. After busy falls, glyph 5 row 1 reads 1010 (the write during busy did not land).
- Out-of-range: wr_row=5 ignored with no corruption of rows 0..4; rd_row=6 -> rd_valid=1, rd_data=0. rd_col=3 with GLYPH_W=4 valid; rerun with GLYPH_W=6, NUM_GLYPHS=3, GLYPH_H=7 and a matching DEFAULT_GLYPH -> init takes 21 cycles and readback matches the pattern.
- Assert rst at init cycle 40 -> busy stays high a full 80 cycles after release and all glyphs read back the default pattern.
